aes_arbiter: RTL and testbench

- Shares one AES decryption core between N_REQ requesters, e.g. the Avalon-MM software interface and a DMA engine.
- Arbitrates round-robin, latches the winner's key and ciphertext, and drives the core's start/done handshake.
- Returns the plaintext to the winner with a one-cycle acknowledge.
- Raises an error pulse if the core does not finish within TIMEOUT cycles.
- Sits between the requesters and the AES core (ports AES_START/AES_DONE/AES_KEY/AES_MSG_ENC/AES_MSG_DEC).

---
 rtl/aes_arbiter.sv | 113 +++++++++++
 tb/tb_aes_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin arbiter sharing one AES decryption core between N_REQ requesters
//   CLK, RESET_N                     clock (rising edge), asynchronous active-low reset
//   REQ, REQ_KEY, REQ_MSG            per-requester request level, key and ciphertext (128-bit packed)
//   ACK, RESULT, ERR                 one-cycle acknowledge, plaintext, timeout flag with ACK
//   BUSY                             high in every state except IDLE
//   AES_START, AES_KEY, AES_MSG_ENC  start level and registered operands to the core
//   AES_DONE, AES_MSG_DEC            core completion level and plaintext
module aes_arbiter #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [N_REQ-1:0]     REQ,
   input  logic [128*N_REQ-1:0] REQ_KEY,
   input  logic [128*N_REQ-1:0] REQ_MSG,
   output logic [N_REQ-1:0]     ACK,
   output logic [127:0]         RESULT,
   output logic                 ERR,
   output logic                 BUSY,
   output logic                 AES_START,
   output logic [127:0]         AES_KEY,
   output logic [127:0]         AES_MSG_ENC,
   input  logic                 AES_DONE,
   input  logic [127:0]         AES_MSG_DEC
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] CLEAR = 2'd3;
   logic [1:0]    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [127:0]  key_q, key_d, msg_q, msg_d, res_q, res_d;
   logic          err_q, err_d;
   // Scan downward so the last hit is the first set bit after ptr (with wrap).
   always_comb begin
      int j;
      j = 0;
      sel = ptr_q;
      for (int i = N_REQ; i >= 1; i--) begin
         j = (int'(ptr_q) + i) % N_REQ;
         if (REQ[j[IW-1:0]]) sel = j[IW-1:0];
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      msg_d   = msg_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (|REQ) begin
            idx_d   = sel;
            key_d   = REQ_KEY[128*sel +: 128];
            msg_d   = REQ_MSG[128*sel +: 128];
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            // A completion in the timeout cycle still counts as success.
            if (AES_DONE) begin
               res_d   = AES_MSG_DEC;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            ptr_d   = idx_q;
            state_d = CLEAR;
         end
         // Wait out a stale DONE so it cannot complete the next job.
         default: if (!AES_DONE) state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         key_q   <= '0;
         msg_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         msg_q   <= msg_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end
   assign ACK         = (state_q == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
   assign ERR         = (state_q == RESP) && err_q;
   assign BUSY        = state_q != IDLE;
   assign AES_START   = state_q == RUN;
   assign AES_KEY     = key_q;
   assign AES_MSG_ENC = msg_q;
   assign RESULT      = res_q;
endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed self-checking bench for aes_arbiter with a behavioural core model
module tb_aes_arbiter;
   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] M0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] M1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P1 = M1 ^ K1;
   logic         CLK = 1'b0;
   logic         RESET_N = 1'b0;
   logic [1:0]   REQ = '0;
   logic [255:0] REQ_KEY = {K1, K0};
   logic [255:0] REQ_MSG = {M1, M0};
   logic [1:0]   ACK;
   logic [127:0] RESULT, AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
   logic         ERR, BUSY, AES_START;
   logic         AES_DONE = 1'b0;
   int n_chk = 0, n_fail = 0;
   int lat = 10, extra = 0, c = 0, h = 0;
   bit dead = 1'b0;
   aes_arbiter #(.N_REQ(2), .TIMEOUT(16)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .REQ_KEY(REQ_KEY), .REQ_MSG(REQ_MSG),
      .ACK(ACK), .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY), .AES_START(AES_START),
      .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC), .AES_DONE(AES_DONE), .AES_MSG_DEC(AES_MSG_DEC)
   );
   always #5 CLK = ~CLK;
   // Core model: DONE after lat START cycles, held extra cycles after START drops.
   always @(posedge CLK) begin
      if (AES_START) begin
         c <= c + 1;
         h <= extra;
         if (!dead && c + 1 >= lat) AES_DONE <= 1'b1;
      end else begin
         c <= 0;
         if (h > 0) h <= h - 1;
         else AES_DONE <= 1'b0;
      end
   end
   assign AES_MSG_DEC = !AES_DONE ? '0 : (AES_KEY == K0 && AES_MSG_ENC == M0) ? P0 : AES_MSG_ENC ^ AES_KEY;
   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wait_start(output int n);
      n = 0;
      do begin cyc(1); n++; end while (!AES_START && n < 60);
   endtask
   task automatic wait_ack(output int n);
      n = 0;
      do begin cyc(1); n++; end while (ACK == 2'b00 && n < 60);
   endtask
   initial begin
      int n;
      bit seen;
      cyc(2);
      chk("rst_ack", ACK, 0);
      chk("rst_err", ERR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_start", AES_START, 0);
      chk("rst_result", RESULT, 0);
      chk("rst_key", AES_KEY, 0);
      chk("rst_msg", AES_MSG_ENC, 0);
      RESET_N = 1'b1;
      cyc(1);
      // single request, 10-cycle core
      REQ = 2'b01;
      cyc(1);
      chk("t1_start", AES_START, 1);
      chk("t1_key", AES_KEY, K0);
      chk("t1_msg", AES_MSG_ENC, M0);
      wait_ack(n);
      chk("t1_lat", n, 11);
      chk("t1_ack", ACK, 2'b01);
      chk("t1_result", RESULT, P0);
      chk("t1_err", ERR, 0);
      REQ = 2'b00;
      cyc(1);
      chk("t1_clear", {ACK, BUSY}, 3'b001);
      cyc(1);
      chk("t1_idle", BUSY, 0);
      // both requesting from reset: requester 1 first
      RESET_N = 1'b0;
      cyc(1);
      RESET_N = 1'b1;
      REQ = 2'b11;
      cyc(1);
      chk("t2_key1", AES_KEY, K1);
      chk("t2_msg1", AES_MSG_ENC, M1);
      REQ_KEY[255:128] = ~K1;
      cyc(3);
      chk("t2_latch", AES_KEY, K1);
      REQ_KEY[255:128] = K1;
      wait_ack(n);
      chk("t2_ack1", ACK, 2'b10);
      chk("t2_res1", RESULT, P1);
      REQ = 2'b01;
      cyc(2);
      chk("t2_gap", AES_START, 0);
      cyc(1);
      chk("t2_start0", AES_START, 1);
      chk("t2_key0", AES_KEY, K0);
      chk("t2_msg0", AES_MSG_ENC, M0);
      wait_ack(n);
      chk("t2_ack0", ACK, 2'b01);
      chk("t2_res0", RESULT, P0);
      // continuous requests alternate
      REQ = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_ack(n);
         chk("t3_order", ACK, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      REQ = 2'b00;
      cyc(3);
      // dead core times out after 16 cycles
      dead = 1'b1;
      REQ = 2'b01;
      wait_start(n);
      wait_ack(n);
      chk("t4_lat", n, 16);
      chk("t4_ack", ACK, 2'b01);
      chk("t4_err", ERR, 1);
      chk("t4_result", RESULT, P0);
      REQ = 2'b00;
      dead = 1'b0;
      cyc(1);
      chk("t4_err_clr", ERR, 0);
      cyc(2);
      // DONE in the timeout cycle wins; REQ dropped during RUN still acked
      lat = 15;
      REQ = 2'b10;
      wait_start(n);
      REQ = 2'b00;
      wait_ack(n);
      chk("t5_lat", n, 16);
      chk("t5_ack", ACK, 2'b10);
      chk("t5_err", ERR, 0);
      chk("t5_result", RESULT, P1);
      cyc(3);
      // stale DONE held 3 extra cycles blocks the next start
      lat = 4;
      extra = 3;
      REQ = 2'b01;
      wait_start(n);
      wait_ack(n);
      chk("t6_ack", ACK, 2'b01);
      REQ = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("t6_hold", {AES_START, BUSY}, 2'b01);
      end
      cyc(1);
      chk("t6_idle", BUSY, 0);
      cyc(1);
      chk("t6_start", AES_START, 1);
      chk("t6_key", AES_KEY, K1);
      wait_ack(n);
      chk("t6_ack1", ACK, 2'b10);
      REQ = 2'b00;
      extra = 0;
      cyc(3);
      // asynchronous reset mid-RUN
      lat = 10;
      REQ = 2'b01;
      wait_start(n);
      cyc(4);
      #2 RESET_N = 1'b0;
      #1;
      chk("t7_start", AES_START, 0);
      chk("t7_busy", BUSY, 0);
      chk("t7_key", AES_KEY, 0);
      chk("t7_msg", AES_MSG_ENC, 0);
      chk("t7_result", RESULT, 0);
      REQ = 2'b00;
      cyc(1);
      RESET_N = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         seen |= |ACK;
      end
      chk("t7_no_ack", seen, 0);
      REQ = 2'b11;
      wait_start(n);
      chk("t7_key1", AES_KEY, K1);
      wait_ack(n);
      chk("t7_ack", ACK, 2'b10);
      REQ = 2'b00;
      cyc(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
